// File: rtl/arb_rr_pkg.sv
// arb_rr_pkg: shared types and helpers for the round-robin arbiter controller.
package arb_rr_pkg;
  typedef enum logic [1:0] {ARB_IDLE, ARB_OWN, ARB_GAP} arb_state_e;
  localparam int ARB_MAX_N = 16;
  function automatic logic [3:0] onehot_to_idx(input logic [ARB_MAX_N-1:0] oh);
    onehot_to_idx = '0;
    for (int i = 0; i < ARB_MAX_N; i++)
      if (oh[i]) onehot_to_idx = 4'(i);
  endfunction
endpackage

// File: rtl/arb_rr_pick.sv
// arb_rr_pick: rotating-priority picker, first set request bit after last (wrapping).
module arb_rr_pick #(
  parameter int N = 2,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  request,
  input  logic [IW-1:0] last,
  output logic          valid,
  output logic [IW-1:0] idx
);
  always_comb begin
    valid = 1'b0;
    idx = '0;
    // scan from the far end so the nearest candidate after last is assigned last
    for (int k = N; k >= 1; k--) begin
      if (request[(int'(last) + k) % N]) begin
        valid = 1'b1;
        idx = IW'((int'(last) + k) % N);
      end
    end
  end
endmodule

// File: rtl/arb_rr_ctrl.sv
// arb_rr_ctrl: N-way round-robin arbiter with registered grant, hold limit and inter-grant gap.
// Define ARB_RR_STATS_EN to add saturating per-requester grant and timeout counters.
module arb_rr_ctrl
  import arb_rr_pkg::*;
#(
  parameter int N = 2,
  parameter int MAX_HOLD = 8,
  parameter int GAP = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [N-1:0]         request,
  input  logic                 done,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] grant_id,
  output logic                 busy,
  output logic                 timeout
`ifdef ARB_RR_STATS_EN
  ,
  output logic [15:0]          grant_count [N],
  output logic [15:0]          timeout_count
`endif
);
  localparam int IW = $clog2(N);
  localparam int HW = $clog2(MAX_HOLD + 1) + 1;
  arb_state_e state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [1:0] gap_q, gap_d;
  logic [N-1:0] grant_q, grant_d;
  logic [IW-1:0] id_q, id_d, last_q, last_d, pick_last, pick_idx;
  logic timeout_q, timeout_d, pick_valid, rel_done, rel_to, leave, arb;
  // at a back-to-back release the outgoing owner must already count as last
  assign pick_last = (state_q == ARB_OWN) ? id_q : last_q;
  arb_rr_pick #(.N(N)) u_pick (
    .request(request),
    .last   (pick_last),
    .valid  (pick_valid),
    .idx    (pick_idx)
  );
  always_comb begin
    state_d = state_q;
    hold_d = hold_q;
    gap_d = gap_q;
    grant_d = grant_q;
    last_d = last_q;
    timeout_d = 1'b0;
    rel_done = done | ~|(request & grant_q);
    rel_to = (MAX_HOLD != 0) && (hold_q == HW'(MAX_HOLD));
    leave = (state_q == ARB_OWN) && (rel_done || rel_to);
    arb = (state_q == ARB_IDLE) || (state_q == ARB_GAP && gap_q == 2'(GAP - 1)) || (leave && GAP == 0);
    if (state_q == ARB_OWN) hold_d = hold_q + 1'b1;
    if (state_q == ARB_GAP) gap_d = gap_q + 1'b1;
    if (leave) begin
      grant_d = '0;
      last_d = id_q;
      hold_d = '0;
      gap_d = '0;
      timeout_d = rel_to & ~rel_done;
      state_d = (GAP > 0) ? ARB_GAP : ARB_IDLE;
    end
    if (arb) begin
      state_d = pick_valid ? ARB_OWN : ARB_IDLE;
      if (pick_valid) begin
        grant_d = N'(1) << pick_idx;
        hold_d = HW'(1);
      end
    end
    id_d = IW'(onehot_to_idx(ARB_MAX_N'(grant_d)));
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ARB_IDLE;
      hold_q <= '0;
      gap_q <= '0;
      grant_q <= '0;
      id_q <= '0;
      last_q <= IW'(N - 1);
      timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q <= hold_d;
      gap_q <= gap_d;
      grant_q <= grant_d;
      id_q <= id_d;
      last_q <= last_d;
      timeout_q <= timeout_d;
    end
  end
  assign grant = grant_q;
  assign grant_id = id_q;
  assign busy = |grant_q;
  assign timeout = timeout_q;
  always_ff @(posedge clk) begin
    if (reset_n) assert ($onehot0(grant_q));
  end
`ifdef ARB_RR_STATS_EN
  logic [15:0] gc_q [N];
  logic [15:0] gc_d [N];
  logic [15:0] tc_q, tc_d;
  always_comb begin
    for (int i = 0; i < N; i++)
      gc_d[i] = gc_q[i] + 16'((arb && pick_valid && int'(pick_idx) == i && gc_q[i] != 16'hFFFF) ? 1 : 0);
    tc_d = tc_q + 16'((timeout_d && tc_q != 16'hFFFF) ? 1 : 0);
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N; i++) gc_q[i] <= '0;
      tc_q <= '0;
    end else begin
      for (int i = 0; i < N; i++) gc_q[i] <= gc_d[i];
      tc_q <= tc_d;
    end
  end
  assign grant_count = gc_q;
  assign timeout_count = tc_q;
`endif
endmodule

// File: tb/tb_arb_rr_ctrl.sv
// tb_arb_rr_ctrl: directed scoreboard bench for arb_rr_ctrl (N=2/GAP=1 and N=4/GAP=0 instances).
module tb_arb_rr_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_n;
  logic [1:0] req2, g2;
  logic done2, id2, busy2, to2;
  logic [3:0] req4, g4;
  logic [1:0] id4;
  logic done4, busy4, to4;
`ifdef ARB_RR_STATS_EN
  logic [15:0] gc2 [2];
  logic [15:0] gc4 [4];
  logic [15:0] tc2, tc4;
`endif
  arb_rr_ctrl #(.N(2), .MAX_HOLD(8), .GAP(1)) dut (
    .clk(clk), .reset_n(reset_n), .request(req2), .done(done2),
    .grant(g2), .grant_id(id2), .busy(busy2), .timeout(to2)
`ifdef ARB_RR_STATS_EN
    , .grant_count(gc2), .timeout_count(tc2)
`endif
  );
  arb_rr_ctrl #(.N(4), .MAX_HOLD(8), .GAP(0)) dut4 (
    .clk(clk), .reset_n(reset_n), .request(req4), .done(done4),
    .grant(g4), .grant_id(id4), .busy(busy4), .timeout(to4)
`ifdef ARB_RR_STATS_EN
    , .grant_count(gc4), .timeout_count(tc4)
`endif
  );
  typedef struct {
    string tag;
    logic [7:0] v;
  } exp_t;
  exp_t sb[$];
  int n_chk = 0;
  int fails = 0;
  wire [7:0] obs2 = {2'b00, g2, 1'b0, id2, busy2, to2};
  wire [7:0] obs4 = {g4, id4, busy4, to4};
  function automatic logic [7:0] mk(input logic [3:0] g, input logic to);
    logic [1:0] id;
    id = g[1] ? 2'd1 : g[2] ? 2'd2 : g[3] ? 2'd3 : 2'd0;
    return {g, id, |g, to};
  endfunction
  task automatic push(input string tag, input logic [3:0] g, input logic to);
    exp_t e;
    e.tag = tag;
    e.v = mk(g, to);
    sb.push_back(e);
  endtask
  task automatic chk(input logic [7:0] obs);
    exp_t e;
    e = sb.pop_front();
    n_chk++;
    assert (obs === e.v) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", e.tag, obs, e.v);
    end
  endtask
  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic cyc2(input string tag, input logic [1:0] r, input logic d, input logic [1:0] eg, input logic eto);
    @(negedge clk);
    req2 = r;
    done2 = d;
    push(tag, {2'b00, eg}, eto);
    @(posedge clk);
    #1;
    chk(obs2);
  endtask
  task automatic cyc4(input string tag, input logic [3:0] r, input logic d, input logic [3:0] eg);
    @(negedge clk);
    req4 = r;
    done4 = d;
    push(tag, eg, 1'b0);
    @(posedge clk);
    #1;
    chk(obs4);
  endtask
  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    req2 = '0;
    done2 = 1'b0;
    req4 = '0;
    done4 = 1'b0;
    #1;
    push("reset2", 4'b0, 1'b0);
    chk(obs2);
    push("reset4", 4'b0, 1'b0);
    chk(obs4);
    @(negedge clk);
    reset_n = 1'b1;
  endtask
  initial begin
    reset_n = 1'b0;
    req2 = '0;
    done2 = 1'b0;
    req4 = '0;
    done4 = 1'b0;
    do_reset();
    cyc2("t1_grant", 2'b01, 1'b0, 2'b01, 1'b0);
    cyc2("t1_hold2", 2'b01, 1'b0, 2'b01, 1'b0);
    cyc2("t1_hold3", 2'b01, 1'b0, 2'b01, 1'b0);
    cyc2("t1_drop", 2'b00, 1'b0, 2'b00, 1'b0);
    cyc2("t1_idle", 2'b00, 1'b0, 2'b00, 1'b0);
    do_reset();
    cyc2("t2_g0", 2'b11, 1'b0, 2'b01, 1'b0);
    cyc2("t2_rel0", 2'b11, 1'b1, 2'b00, 1'b0);
    cyc2("t2_g1", 2'b11, 1'b0, 2'b10, 1'b0);
    cyc2("t2_rel1", 2'b11, 1'b1, 2'b00, 1'b0);
    cyc2("t2_g0b", 2'b11, 1'b0, 2'b01, 1'b0);
    cyc2("t2_rel", 2'b00, 1'b1, 2'b00, 1'b0);
    cyc2("t2_idle", 2'b00, 1'b0, 2'b00, 1'b0);
    cyc2("t3_grant", 2'b01, 1'b0, 2'b01, 1'b0);
    for (int i = 0; i < 7; i++) cyc2("t3_hold", 2'b01, 1'b0, 2'b01, 1'b0);
    cyc2("t3_timeout", 2'b11, 1'b0, 2'b00, 1'b1);
    cyc2("t3_next", 2'b11, 1'b0, 2'b10, 1'b0);
    for (int i = 0; i < 7; i++) cyc2("t4_hold", 2'b11, 1'b0, 2'b10, 1'b0);
    cyc2("t4_done_at_max", 2'b11, 1'b1, 2'b00, 1'b0);
    cyc2("t4_idle", 2'b00, 1'b0, 2'b00, 1'b0);
`ifdef ARB_RR_STATS_EN
    chk16("t4_timeout_count", tc2, 16'd1);
`endif
    cyc2("t5_grant", 2'b01, 1'b0, 2'b01, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    push("t5_async_reset", 4'b0, 1'b0);
    chk(obs2);
    @(negedge clk);
    req2 = '0;
    reset_n = 1'b1;
    cyc2("t5_req1_only", 2'b10, 1'b0, 2'b10, 1'b0);
    do_reset();
    cyc2("t5_both", 2'b11, 1'b0, 2'b01, 1'b0);
    do_reset();
    cyc4("t6_g0", 4'b1111, 1'b0, 4'b0001);
    cyc4("t6_g1", 4'b1111, 1'b1, 4'b0010);
    cyc4("t6_g2", 4'b1111, 1'b1, 4'b0100);
    cyc4("t6_g3", 4'b1111, 1'b1, 4'b1000);
    cyc4("t6_g0b", 4'b1111, 1'b1, 4'b0001);
    cyc4("t6_rel", 4'b0000, 1'b1, 4'b0000);
`ifdef ARB_RR_STATS_EN
    chk16("t6_gc0", gc4[0], 16'd2);
    chk16("t6_gc1", gc4[1], 16'd1);
    chk16("t6_gc2", gc4[2], 16'd1);
    chk16("t6_gc3", gc4[3], 16'd1);
    chk16("t6_tc", tc4, 16'd0);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, fails);
    $finish;
  end
endmodule
